sparc_trap_prio: RTL and testbench



---
 rtl/sparc_trap_prio.sv | 129 ++++++++++++
 tb/tb_sparc_trap_prio.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sparc_trap_prio.sv
// Registered trap-priority unit: sticky pending bits, masked/ET-gated lowest-index select, valid/ack posting.
// Optional build macro SPARC_TRAP_PREEMPT_EN lets a higher-priority source replace the posted tt before ack.
module sparc_trap_prio #(
  parameter int N_TRAPS = 6,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_TRAPS-1:0] trap_req,
  input  logic [N_TRAPS-1:0] trap_mask,
  input  logic               et,
  input  logic               flush,
  input  logic               trap_ack,
  output logic               trap_valid,
  output logic [IDX_W-1:0]   tt,
  output logic [N_TRAPS-1:0] pending
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] POSTED = 1'b1;

  logic [0:0]         state_r;
  logic [0:0]         state_next_s;
  logic [N_TRAPS-1:0] pend_r;
  logic [N_TRAPS-1:0] pend_next_s;
  logic [N_TRAPS-1:0] clr_s;
  logic [N_TRAPS-1:0] elig_s;
  logic [IDX_W-1:0]   tt_r;
  logic [IDX_W-1:0]   tt_next_s;
  logic [IDX_W-1:0]   sel_s;
  logic               valid_r;
  logic               valid_next_s;
  logic               found_s;
  logic               ack_s;

  // Lowest set index wins; scanning downward lets the last hit be the lowest one.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_TRAPS-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = N_TRAPS - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_W'(i) : idx;
    end
    return idx;
  endfunction

  // Source 0 ignores both its mask bit and PSR.ET.
  assign elig_s  = pend_r
                 & ~(trap_mask & {{(N_TRAPS-1){1'b1}}, 1'b0})
                 & {{(N_TRAPS-1){et}}, 1'b1};
  assign found_s = |elig_s;
  assign sel_s   = lowest_idx(elig_s);
  assign ack_s   = valid_r & trap_ack;

  // Clear mask from an accepted ack and/or a flush; new requests are OR-ed in afterwards so set wins.
  always_comb begin
    clr_s = {N_TRAPS{1'b0}};
    if (ack_s) begin
      clr_s = clr_s | ({{(N_TRAPS-1){1'b0}}, 1'b1} << tt_r);
    end else begin
      clr_s = clr_s;
    end
    if (flush) begin
      clr_s = clr_s | {{(N_TRAPS-1){1'b1}}, 1'b0};
    end else begin
      clr_s = clr_s;
    end
    pend_next_s = (pend_r & ~clr_s) | trap_req;
  end

  // Posting FSM: IDLE latches the selected index, POSTED holds it until ack or flush.
  always_comb begin
    state_next_s = state_r;
    tt_next_s    = tt_r;
    valid_next_s = valid_r;
    case (state_r)
      IDLE: begin
        if (found_s && !flush) begin
          tt_next_s    = sel_s;
          valid_next_s = 1'b1;
          state_next_s = POSTED;
        end else begin
          valid_next_s = 1'b0;
          state_next_s = IDLE;
        end
      end
      POSTED: begin
        if (ack_s || flush) begin
          valid_next_s = 1'b0;
          state_next_s = IDLE;
        end
`ifdef SPARC_TRAP_PREEMPT_EN
        else if (found_s && (sel_s < tt_r)) begin
          tt_next_s    = sel_s;
          valid_next_s = 1'b1;
          state_next_s = POSTED;
        end
`endif
        else begin
          valid_next_s = 1'b1;
          state_next_s = POSTED;
        end
      end
      default: begin
        valid_next_s = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  // State, pending and output registers; reset drops everything including in-flight requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      pend_r  <= {N_TRAPS{1'b0}};
      tt_r    <= {IDX_W{1'b0}};
      valid_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      pend_r  <= pend_next_s;
      tt_r    <= tt_next_s;
      valid_r <= valid_next_s;
    end
  end

  assign trap_valid = valid_r;
  assign tt         = tt_r;
  assign pending    = pend_r;

endmodule

// File: tb/tb_sparc_trap_prio.sv
// Bench for sparc_trap_prio: per-cycle vector table with a scoreboard of expected outputs, plus reset sequences.
// Expectations for the preemption case follow SPARC_TRAP_PREEMPT_EN when the bench is built with it.
module tb_sparc_trap_prio;

`ifdef SPARC_TRAP_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  typedef struct {
    logic [5:0] req;
    logic [5:0] mask;
    logic       et;
    logic       flush;
    logic       ack;
    logic       v;
    logic [2:0] t;
    logic [5:0] p;
  } vec_t;

  typedef struct {
    logic       v;
    logic [2:0] t;
    logic [5:0] p;
    int         idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] trap_req;
  logic [5:0] trap_mask;
  logic       et;
  logic       flush;
  logic       trap_ack;
  logic       trap_valid;
  logic [2:0] tt;
  logic [5:0] pending;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  sparc_trap_prio #(.N_TRAPS(6), .IDX_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .trap_req  (trap_req),
    .trap_mask (trap_mask),
    .et        (et),
    .flush     (flush),
    .trap_ack  (trap_ack),
    .trap_valid(trap_valid),
    .tt        (tt),
    .pending   (pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [2:0] t, input logic [5:0] p);
    check({tag, ".valid"},   32'(trap_valid), 32'(v));
    check({tag, ".tt"},      32'(tt),         32'(t));
    check({tag, ".pending"}, 32'(pending),    32'(p));
  endtask

  task automatic add(input logic [5:0] req, input logic [5:0] mask, input logic e, input logic f,
                     input logic a, input logic v, input logic [2:0] t, input logic [5:0] p);
    vec_t x;
    x.req = req; x.mask = mask; x.et = e; x.flush = f; x.ack = a;
    x.v = v; x.t = t; x.p = p;
    vecs.push_back(x);
  endtask

  // Drive one cycle of inputs, queue its expected result, compare after the edge.
  task automatic step(input vec_t x, input int idx);
    exp_t e;
    trap_req  = x.req;
    trap_mask = x.mask;
    et        = x.et;
    flush     = x.flush;
    trap_ack  = x.ack;
    e.v = x.v; e.t = x.t; e.p = x.p; e.idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard: empty at step %0d, expected one entry", idx);
    end else begin
      e = sb.pop_front();
      check_outs($sformatf("vec%0d", e.idx), e.v, e.t, e.p);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    localparam logic [5:0] Z  = 6'b000000;
    localparam logic [5:0] M1 = 6'b000010;
    localparam logic [5:0] MA = 6'b111111;
    logic [2:0] t40;
    vec_t zero_v;

    t40 = PRE ? 3'd4 : 3'd1;
    zero_v.req = Z; zero_v.mask = Z; zero_v.et = 1'b1; zero_v.flush = 1'b0; zero_v.ack = 1'b0;
    zero_v.v = 1'b0; zero_v.t = 3'd0; zero_v.p = Z;

    //   req        mask et    flush ack   valid tt     pending
    add(6'b000100, Z,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 6'b000100);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 6'b000100);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 6'b000100);
    add(Z,         Z,  1'b1, 1'b0, 1'b1, 1'b0, 3'd2, Z);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b0, 3'd2, Z);
    add(Z,         Z,  1'b1, 1'b0, 1'b1, 1'b0, 3'd2, Z);
    add(6'b101000, Z,  1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 6'b101000);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 6'b101000);
    add(Z,         Z,  1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 6'b100000);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 6'b100000);
    add(Z,         Z,  1'b1, 1'b0, 1'b1, 1'b0, 3'd5, Z);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b0, 3'd5, Z);
    add(6'b000110, Z,  1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 6'b000110);
    add(Z,         Z,  1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 6'b000110);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 6'b000110);
    add(Z,         Z,  1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 6'b000100);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 6'b000100);
    add(Z,         Z,  1'b1, 1'b0, 1'b1, 1'b0, 3'd2, Z);
    add(6'b000110, M1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 6'b000110);
    add(Z,         M1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 6'b000110);
    add(Z,         M1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 6'b000010);
    add(Z,         M1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 6'b000010);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 6'b000010);
    add(Z,         Z,  1'b1, 1'b0, 1'b1, 1'b0, 3'd1, Z);
    add(6'b000001, MA, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 6'b000001);
    add(Z,         MA, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 6'b000001);
    add(Z,         MA, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, Z);
    add(6'b001000, Z,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 6'b001000);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 6'b001000);
    add(6'b001000, Z,  1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 6'b001000);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 6'b001000);
    add(Z,         Z,  1'b1, 1'b0, 1'b1, 1'b0, 3'd3, Z);
    add(6'b010000, Z,  1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 6'b010000);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 6'b010000);
    add(6'b000010, Z,  1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 6'b010010);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, PRE ? 3'd1 : 3'd4, 6'b010010);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, PRE ? 3'd1 : 3'd4, 6'b010010);
    add(Z,         Z,  1'b1, 1'b0, 1'b1, 1'b0, PRE ? 3'd1 : 3'd4, PRE ? 6'b010000 : 6'b000010);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, PRE ? 3'd4 : 3'd1, PRE ? 6'b010000 : 6'b000010);
    add(Z,         Z,  1'b1, 1'b0, 1'b1, 1'b0, t40, Z);
    add(6'b010011, Z,  1'b1, 1'b0, 1'b0, 1'b0, t40, 6'b010011);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 6'b010011);
    add(Z,         Z,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 6'b000001);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 6'b000001);
    add(6'b000110, Z,  1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 6'b000111);
    add(Z,         Z,  1'b1, 1'b1, 1'b1, 1'b0, 3'd0, Z);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, Z);
    add(6'b000100, Z,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 6'b000100);
    add(Z,         Z,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0, Z);
    add(6'b000100, Z,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 6'b000100);
    add(Z,         Z,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0, Z);
    add(6'b100000, Z,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 6'b100000);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 6'b100000);
    add(Z,         Z,  1'b1, 1'b1, 1'b0, 1'b0, 3'd5, Z);
    add(6'b001000, Z,  1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 6'b001000);
    add(Z,         Z,  1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 6'b001000);

    // Reset with requests held high: they must not survive release.
    reset_n   = 1'b0;
    trap_req  = 6'b111111;
    trap_mask = Z;
    et        = 1'b1;
    flush     = 1'b0;
    trap_ack  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("in_reset", 1'b0, 3'd0, Z);
    trap_req = Z;
    reset_n  = 1'b1;
    step(zero_v, -1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], i);
    end

    // Async reset while tt=3 is posted: outputs clear before the next edge.
    reset_n  = 1'b0;
    trap_req = 6'b001000;
    #1;
    check_outs("async_reset", 1'b0, 3'd0, Z);
    @(posedge clk);
    #1;
    check_outs("reset_hold", 1'b0, 3'd0, Z);
    trap_req = Z;
    reset_n  = 1'b1;
    step(zero_v, -2);
    step(zero_v, -3);

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
